// File: rtl/float_multiplier.sv
// Single-shot floating-point multiplier: captures a/b after reset release, yields a
// round-to-nearest-even product four edges later and holds it until the next reset.
module float_multiplier #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 7,
    parameter int BIAS      = 127,
    parameter bit E4M3_MODE = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic [EXP_W+MAN_W:0]   y,
    output logic                   is_output_valid,
    output logic [2:0]             state_dbg
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = E4M3_MODE ? {1'b0, {(W-1){1'b1}}}
                                              : {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CAPTURE, MULT, NORM, DONE} state_t;
    state_t state, state_next;

    logic [W-1:0]          a_r, b_r, res_r, special_y_r, special_y_c;
    logic                  special_r, special_c, sign_r;
    logic [PW-1:0]         prod_r;
    logic signed [XW-1:0]  exp_r;

    assign state_dbg = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = CAPTURE;
            CAPTURE: state_next = MULT;
            MULT:    state_next = NORM;
            NORM:    state_next = DONE;
            default: state_next = DONE;
        endcase
    end

    // Operand field decode from the captured registers.
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             sign_c, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        ea     = a_r[W-2:MAN_W];
        eb     = b_r[W-2:MAN_W];
        ma     = a_r[MAN_W-1:0];
        mb     = b_r[MAN_W-1:0];
        sign_c = a_r[W-1] ^ b_r[W-1];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_nan  = E4M3_MODE ? (&ea && &ma) : (&ea && |ma);
        b_nan  = E4M3_MODE ? (&eb && &mb) : (&eb && |mb);
        a_inf  = !E4M3_MODE && &ea && (ma == '0);
        b_inf  = !E4M3_MODE && &eb && (mb == '0);

        special_c   = 1'b1;
        special_y_c = QNAN;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            special_y_c = QNAN;
        else if (a_inf || b_inf)
            special_y_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (a_zero || b_zero)
            special_y_c = {sign_c, {(W-1){1'b0}}};
        else
            special_c = 1'b0;
    end

    // Normalise so the leading one sits at PW-1, then round to nearest even.
    logic [PW-1:0]         norm;
    logic signed [XW-1:0]  exp_n, exp_f;
    logic [MAN_W-1:0]      mant, mant_rnd;
    logic                  guard, sticky, round_up, carry;
    logic [W-1:0]          result_c;

    always_comb begin
        norm     = prod_r[PW-1] ? prod_r : {prod_r[PW-2:0], 1'b0};
        exp_n    = exp_r + {{(XW-1){1'b0}}, prod_r[PW-1]};
        mant     = norm[PW-2 -: MAN_W];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = guard && (sticky || mant[0]);
        {carry, mant_rnd} = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
        exp_f    = exp_n + {{(XW-1){1'b0}}, carry};

        result_c = {sign_r, exp_f[EXP_W-1:0], mant_rnd};
        if (special_r)
            result_c = special_y_r;
        else if (exp_f[XW-1] || exp_f == '0)
            result_c = {sign_r, {(W-1){1'b0}}};
        else if (E4M3_MODE) begin
            if (exp_f > $signed(XW'(EXP_MAX)) ||
                (exp_f == $signed(XW'(EXP_MAX)) && &mant_rnd))
                result_c = {sign_r, {EXP_W{1'b1}}, {(MAN_W-1){1'b1}}, 1'b0};
        end else if (exp_f >= $signed(XW'(EXP_MAX)))
            result_c = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            a_r             <= '0;
            b_r             <= '0;
            special_r       <= 1'b0;
            special_y_r     <= '0;
            sign_r          <= 1'b0;
            prod_r          <= '0;
            exp_r           <= '0;
            res_r           <= '0;
            y               <= '0;
            is_output_valid <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    a_r <= a;
                    b_r <= b;
                end
                CAPTURE: begin
                    special_r   <= special_c;
                    special_y_r <= special_y_c;
                    sign_r      <= sign_c;
                    prod_r      <= PW'({1'b1, ma}) * PW'({1'b1, mb});
                    exp_r       <= $signed({2'b00, ea}) + $signed({2'b00, eb})
                                   - $signed(XW'(BIAS));
                end
                MULT: res_r <= result_c;
                NORM: begin
                    y               <= res_r;
                    is_output_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_float_multiplier.sv
// Directed checks of an E4M3 and a BF16 instance sharing one clock and reset.
`timescale 1ns/1ps
module tb_float_multiplier;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, y8;
    logic [15:0] a16 = '0, b16 = '0, y16;
    logic        v8, v16;
    logic [2:0]  st8, st16;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    float_multiplier #(.EXP_W(4), .MAN_W(3), .BIAS(7), .E4M3_MODE(1)) dut_e4m3 (
        .clock(clock), .reset(reset), .a(a8), .b(b8), .y(y8),
        .is_output_valid(v8), .state_dbg(st8));

    float_multiplier #(.EXP_W(8), .MAN_W(7), .BIAS(127), .E4M3_MODE(0)) dut_bf16 (
        .clock(clock), .reset(reset), .a(a16), .b(b16), .y(y16),
        .is_output_valid(v16), .state_dbg(st16));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // One full reset cycle with both instances computing, checked 5 edges after release.
    task automatic run_e4(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] exp);
        do_reset();
        a8 = va; b8 = vb;
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check({tag, "_y"}, {8'h00, y8}, {8'h00, exp});
        check({tag, "_valid"}, {15'd0, v8}, 16'd1);
    endtask

    task automatic run_bf(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] exp);
        do_reset();
        a16 = va; b16 = vb;
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check({tag, "_y"}, y16, exp);
        check({tag, "_valid"}, {15'd0, v16}, 16'd1);
    endtask

    initial begin
        a8 = 8'h40; b8 = 8'h40; a16 = 16'h3F80; b16 = 16'h3F80;
        repeat (2) @(posedge clock);
        #1;
        check("reset_y8", {8'h00, y8}, 16'h0000);
        check("reset_v8", {15'd0, v8}, 16'd0);
        check("reset_y16", y16, 16'h0000);
        check("reset_state", {13'd0, st16}, 16'd0);

        run_e4("e4_2x2", 8'h40, 8'h40, 8'h48);
        run_e4("e4_1x1", 8'h38, 8'h38, 8'h38);
        run_e4("e4_1xm1", 8'h38, 8'hB8, 8'hB8);
        run_e4("e4_2x1p125", 8'h40, 8'h39, 8'h41);
        run_e4("e4_neg", 8'hAC, 8'hC0, 8'h34);
        run_e4("e4_zero", 8'h00, 8'h00, 8'h00);
        run_e4("e4_sat", 8'h7E, 8'h40, 8'h7E);
        run_e4("e4_nan", 8'h7F, 8'h38, 8'h7F);
        run_e4("e4_negzero", 8'h80, 8'h40, 8'h80);

        run_bf("bf_1xm1", 16'h3F80, 16'hBF80, 16'hBF80);
        run_bf("bf_zero", 16'h0000, 16'h0000, 16'h0000);
        run_bf("bf_m1xm1", 16'hBF80, 16'hBF80, 16'h3F80);
        run_bf("bf_frac", 16'hBF40, 16'h3FE0, 16'hBFA8);
        run_bf("bf_rne", 16'h4348, 16'h3A83, 16'h3E4D);
        run_bf("bf_ovf", 16'h7F00, 16'h7F00, 16'h7F80);
        run_bf("bf_infx0", 16'h7F80, 16'h0000, 16'h7FC0);
        run_bf("bf_infxneg", 16'h7F80, 16'hBF80, 16'hFF80);
        run_bf("bf_nan", 16'h7FC1, 16'h3F80, 16'h7FC0);
        run_bf("bf_unf", 16'h0080, 16'h0080, 16'h0000);

        // Valid stays low for three edges after release and rises on the fourth.
        do_reset();
        a16 = 16'h3F80; b16 = 16'hBF80;
        reset = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clock);
            #1;
            check($sformatf("latency_edge%0d", e), {15'd0, v16}, (e == 4) ? 16'd1 : 16'd0);
        end

        // Reset asserted while in MULT clears outputs immediately, then recomputes.
        do_reset();
        a16 = 16'hBF80; b16 = 16'hBF80;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("abort_in_mult_state", {13'd0, st16}, 16'd2);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_y", y16, 16'h0000);
        check("abort_valid", {15'd0, v16}, 16'd0);
        check("abort_state", {13'd0, st16}, 16'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("recompute_y", y16, 16'h3F80);
        check("recompute_valid", {15'd0, v16}, 16'd1);

        // Operands changed after the capture edge must not disturb the result.
        do_reset();
        a8 = 8'h40; b8 = 8'h39; a16 = 16'hBF40; b16 = 16'h3FE0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        a8 = 8'h38; b8 = 8'hB8; a16 = 16'h0000; b16 = 16'h7F80;
        repeat (5) @(posedge clock);
        #1;
        check("late_input_e4", {8'h00, y8}, 16'h0041);
        check("late_input_bf", y16, 16'hBFA8);
        repeat (3) @(posedge clock);
        #1;
        check("hold_bf", y16, 16'hBFA8);
        check("hold_valid", {15'd0, v16}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
